// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, FSM states and the ZCNV flag record.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND = 5'b00000,
        OP_OR  = 5'b00001,
        OP_NOT = 5'b00010,
        OP_XOR = 5'b00011,
        OP_ADD = 5'b00100,
        OP_SUB = 5'b00101,
        OP_MUL = 5'b00110,
        OP_LSL = 5'b10000,
        OP_LSR = 5'b10001,
        OP_ASR = 5'b10010
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    localparam int OP_BITS = 5;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per clock, W clocks per product.
module alu_mul_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int CW = $clog2(W);

    logic           busy_r;
    logic [CW-1:0]  cnt_r;
    logic [W-1:0]   a_r;
    logic [2*W-1:0] p_r;
    logic [W:0]     sum_s;
    logic [2*W-1:0] step_s;

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out LSB first.
    assign sum_s  = {1'b0, p_r[2*W-1:W]} + (p_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
    assign step_s = {sum_s, p_r[W-1:1]};

    // prod is the value the final iteration writes, so the caller can capture it on the same edge.
    assign busy = busy_r;
    assign done = busy_r && (cnt_r == {CW{1'b0}});
    assign prod = step_s;

    // Load operands on start, then iterate with the counter running W-1 down to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            a_r    <= {W{1'b0}};
            p_r    <= {(2*W){1'b0}};
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= CW'(W - 1);
            a_r    <= a;
            p_r    <= {{W{1'b0}}, b};
        end else if (busy_r) begin
            p_r <= step_s;
            if (cnt_r == {CW{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and ZCNV flags; MUL runs on the iterative multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic [3:0]   flags,
    output logic         err
);

    localparam logic [W-1:0] W_LIM = W'(W);

    state_e         state_r;
    logic [W-1:0]   result_r, result_hi_r;
    flags_t         flags_r;
    logic           err_r, out_valid_r;

    op_e            op_s;
    logic           in_ready_s, accept_s, start_mul_s;
    logic [W-1:0]   res_s;
    flags_t         flg_s;
    logic           err_s;
    logic [W:0]     add_s, sub_s;
    logic [SHW-1:0] shamt_s;
    logic           sh_big_s;
    logic           mul_busy_s, mul_done_s;
    logic [2*W-1:0] prod_s;

    assign op_s        = op_e'(op);
    assign accept_s    = in_valid && in_ready_s;
    assign start_mul_s = accept_s && (op_s == OP_MUL);
    assign add_s       = {1'b0, in1} + {1'b0, in2};
    assign sub_s       = {1'b0, in1} - {1'b0, in2};
    assign shamt_s     = in2[SHW-1:0];
    assign sh_big_s    = (in2 >= W_LIM);

    alu_mul_iter #(.W(W)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (start_mul_s),
        .a     (in1),
        .b     (in2),
        .busy  (mul_busy_s),
        .done  (mul_done_s),
        .prod  (prod_s)
    );

    // DONE passes out_ready straight through so a new op can follow without a bubble.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            BUSY:    in_ready_s = 1'b0;
            DONE:    in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Single-cycle datapath for every op except MUL.
    always_comb begin
        res_s = {W{1'b0}};
        flg_s = flags_t'(4'b0000);
        err_s = 1'b0;
        case (op_s)
            OP_AND: res_s = in1 & in2;
            OP_OR:  res_s = in1 | in2;
            OP_NOT: res_s = ~in1;
            OP_XOR: res_s = in1 ^ in2;
            OP_ADD: begin
                res_s   = add_s[W-1:0];
                flg_s.c = add_s[W];
                flg_s.v = (in1[W-1] == in2[W-1]) && (add_s[W-1] != in1[W-1]);
            end
            OP_SUB: begin
                res_s   = sub_s[W-1:0];
                flg_s.c = sub_s[W];
                flg_s.v = (in1[W-1] != in2[W-1]) && (sub_s[W-1] != in1[W-1]);
            end
            OP_LSL: begin
                if (sh_big_s) res_s = {W{1'b0}};
                else          res_s = in1 << shamt_s;
            end
            OP_LSR: begin
                if (sh_big_s) res_s = {W{1'b0}};
                else          res_s = in1 >> shamt_s;
            end
            OP_ASR: begin
                if (sh_big_s) res_s = {W{in1[W-1]}};
                else          res_s = $signed(in1) >>> shamt_s;
            end
            OP_MUL: res_s = {W{1'b0}};
            default: begin
                res_s = {W{1'b1}};
                err_s = 1'b1;
            end
        endcase
        if (err_s) begin
            flg_s.z = 1'b0;
            flg_s.n = 1'b0;
        end else begin
            flg_s.z = (res_s == {W{1'b0}});
            flg_s.n = res_s[W-1];
        end
    end

    // Control FSM with all result/flag outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {W{1'b0}};
            result_hi_r <= {W{1'b0}};
            flags_r     <= flags_t'(4'b0000);
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        if (start_mul_s) begin
                            state_r     <= BUSY;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= res_s;
                            result_hi_r <= {W{1'b0}};
                            flags_r     <= flg_s;
                            err_r       <= err_s;
                        end
                    end else if ((state_r == DONE) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mul_busy_s && mul_done_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= prod_s[W-1:0];
                        result_hi_r <= prod_s[2*W-1:W];
                        flags_r     <= '{z: (prod_s[W-1:0] == {W{1'b0}}),
                                         c: (prod_s[2*W-1:W] != {W{1'b0}}),
                                         n: prod_s[W-1],
                                         v: 1'b0};
                        err_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq (W=8) against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] in1, in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, result_hi;
    logic [3:0]   flags;
    logic         err;

    int total = 0;
    int bad   = 0;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {err, Z, C, N, V, hi[7:0], lo[7:0]} from plain integer arithmetic.
    function automatic logic [20:0] model(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, hi;
        logic c, v;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r = 0; hi = 0; c = 1'b0; v = 1'b0;
        case (o)
            5'b10000: r = (ub >= 8) ? 0 : (ua << ub) % 256;
            5'b10001: r = (ub >= 8) ? 0 : ua >> ub;
            5'b10010: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
            5'b00000: r = ua & ub;
            5'b00001: r = ua | ub;
            5'b00010: r = 255 - ua;
            5'b00011: r = ua ^ ub;
            5'b00100: begin
                r = (ua + ub) % 256;
                c = (ua + ub) > 255;
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            5'b00101: begin
                r = (ua - ub + 256) % 256;
                c = ua < ub;
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            5'b00110: begin
                r  = (ua * ub) % 256;
                hi = (ua * ub) / 256;
                c  = hi != 0;
            end
            default: return {1'b1, 4'b0000, 8'h00, 8'hFF};
        endcase
        return {1'b0, (r == 0), c, (r > 127), v, hi[7:0], r[7:0]};
    endfunction

    // Offer an op, wait (bounded) for acceptance, then scramble the operand bus.
    task automatic offer(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
        int n;
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op  = 5'($urandom);
        in1 = 8'($urandom);
        in2 = 8'($urandom);
    endtask

    task automatic check_out(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [3:0] f, input logic e);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_lo"},    {24'd0, result},    {24'd0, lo});
        chk({tag, "_hi"},    {24'd0, result_hi}, {24'd0, hi});
        chk({tag, "_flags"}, {28'd0, flags},     {28'd0, f});
        chk({tag, "_err"},   {31'd0, err},       {31'd0, e});
    endtask

    initial begin
        logic [20:0] exp;
        logic [4:0]  ro;
        logic [7:0]  ra, rb;
        int          n;
        int          exp_lat;
        logic [4:0]  legal [10];
        legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                  5'b00101, 5'b00110, 5'b10000, 5'b10001, 5'b10010};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 5'd0; in1 = 8'd0; in2 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_hi", {24'd0, result_hi}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back ADD then SUB
        out_ready = 1'b1;
        offer(5'b00100, 8'h7F, 8'h01);
        check_out("add", 8'h80, 8'h00, 4'b0011, 1'b0);
        offer(5'b00101, 8'h10, 8'h20);
        check_out("sub", 8'hF0, 8'h00, 4'b0110, 1'b0);

        offer(5'b10010, 8'h80, 8'd3);
        check_out("asr3", 8'hF0, 8'h00, 4'b0010, 1'b0);
        offer(5'b10001, 8'h80, 8'd9);
        check_out("lsr9", 8'h00, 8'h00, 4'b1000, 1'b0);
        offer(5'b10010, 8'h80, 8'd200);
        check_out("asr200", 8'hFF, 8'h00, 4'b0010, 1'b0);
        offer(5'b00010, 8'h0F, 8'h00);
        check_out("not", 8'hF0, 8'h00, 4'b0010, 1'b0);
        @(posedge clk); #1;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // MUL latency and busy behaviour
        offer(5'b00110, 8'hFF, 8'hFF);
        chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
        chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
            chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        check_out("mul", 8'h01, 8'hFE, 4'b0100, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result frozen, a pending offer is not taken until out_ready
        out_ready = 1'b0;
        offer(5'b00011, 8'hA5, 8'h3C);
        check_out("xor", 8'h99, 8'h00, 4'b0010, 1'b0);
        op = 5'b00100; in1 = 8'h01; in2 = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_out("hold", 8'h99, 8'h00, 4'b0010, 1'b0);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_out("after_hold", 8'h02, 8'h00, 4'b0000, 1'b0);

        offer(5'b11111, 8'h12, 8'h34);
        check_out("illegal", 8'hFF, 8'h00, 4'b0000, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of a MUL
        offer(5'b00110, 8'd3, 8'd5);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_flags", {28'd0, flags}, 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            chk("midrst_nopulse", {31'd0, out_valid}, 32'd0);
        end
        offer(5'b00100, 8'd2, 8'd3);
        check_out("add_after_rst", 8'h05, 8'h00, 4'b0000, 1'b0);

        // Random ops against the reference model
        for (int k = 0; k < 150; k++) begin
            n = $urandom_range(0, 11);
            ro = (n < 10) ? legal[n] : 5'($urandom);
            ra = 8'($urandom);
            rb = (ro[4] && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            exp = model(ro, ra, rb);
            exp_lat = (ro == 5'b00110) ? W : 0;
            offer(ro, ra, rb);
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rnd_latency", n, exp_lat);
            check_out("rnd", exp[7:0], exp[15:8], exp[19:16], exp[20]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
